// File: rtl/spi_flash_responder_pkg.sv
// Shared types and constants for the SPI flash responder.
// FAST READ (0x0B) support is controlled by the SPI_FLASH_RESP_FAST_READ_EN macro.
package spi_flash_responder_pkg;

  localparam int ADDR_BITS    = 24;
  localparam int DUMMY_CYCLES = 8;

  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_FAST_READ   = 8'h0B;
  localparam logic [7:0] CMD_JEDEC_ID    = 8'h9F;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    S_DUMMY  = 3'd3,
`endif
    S_DATA   = 3'd4,
    S_ID     = 3'd5,
    S_STATUS = 3'd6,
    S_IGNORE = 3'd7
  } spi_resp_state_e;

  // States in which the responder owns sd[1].
  function automatic logic drives_miso(spi_resp_state_e s);
    return (s == S_DATA) || (s == S_ID) || (s == S_STATUS);
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchronizers for the SPI pins plus single-cycle edge pulses
// derived from the synchronized sck and csb levels.
module spi_flash_responder_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic csb,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_rise,
  output logic csb_fall,
  output logic mosi_sync
);

  logic sck_meta, sck_sync, sck_prev;
  logic csb_meta, csb_sync, csb_prev;
  logic mosi_meta;

  // csb resets high so a deasserted bus does not look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      csb_meta  <= 1'b1;
      csb_sync  <= 1'b1;
      csb_prev  <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sck_meta  <= sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      csb_meta  <= csb;
      csb_sync  <= csb_meta;
      csb_prev  <= csb_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign csb_rise = csb_sync & ~csb_prev;
  assign csb_fall = ~csb_sync & csb_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash emulator: decodes READ / JEDEC ID / READ STATUS over mode-0 SPI
// and serves data from a byte-wide memory port with a one-byte prefetch.
// Define SPI_FLASH_RESP_FAST_READ_EN to add FAST READ (0x0B) with 8 dummy cycles.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_csb_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [7:0]            mem_rdata_i,
  output logic                  busy_o,
  output logic                  underrun_o
);

  spi_resp_state_e state;

  logic sck_rise, sck_fall, csb_rise, csb_fall, mosi_s;

  logic [4:0]           bit_cnt;
  logic [2:0]           out_cnt;
  logic [1:0]           byte_cnt;
  logic [6:0]           shift_in;
  logic [6:0]           shift_out;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           buf_data;
  logic                 buf_valid;
  logic [1:0]           outst;
  logic [1:0]           drop_cnt;
  logic                 miso, oe, mem_req, underrun;
  logic [ADDR_WIDTH-1:0] mem_addr;

`ifdef SPI_FLASH_RESP_FAST_READ_EN
  logic       fast_read;
  logic [2:0] dummy_cnt;
`endif

  logic [7:0]           cmd_byte;
  logic [ADDR_BITS-1:0] addr_next;
  logic [ADDR_BITS-1:0] addr_inc;
  logic [1:0]           outst_after;
  logic                 prefetching;
  logic [7:0]           load_val;

  spi_flash_responder_sync u_sync (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .sck       (spi_sck_i),
    .csb       (spi_csb_i),
    .mosi      (spi_mosi_i),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .csb_rise  (csb_rise),
    .csb_fall  (csb_fall),
    .mosi_sync (mosi_s)
  );

  assign cmd_byte  = {shift_in, mosi_s};
  assign addr_next = {addr[ADDR_BITS-2:0], mosi_s};
  assign addr_inc  = addr + 24'd1;
  // Requests still in flight once this cycle's request/response are accounted for.
  assign outst_after = outst + {1'b0, mem_req} - {1'b0, mem_rvalid_i};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    prefetching = (state == S_DATA);
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    if (state == S_DUMMY) prefetching = 1'b1;
`endif
    load_val = 8'hFF;
    case (state)
      S_DATA:   load_val = buf_valid ? buf_data : 8'hFF;
      S_STATUS: load_val = 8'h00;
      S_ID: begin
        case (byte_cnt)
          2'd0:    load_val = JEDEC_ID[23:16];
          2'd1:    load_val = JEDEC_ID[15:8];
          2'd2:    load_val = JEDEC_ID[7:0];
          default: load_val = 8'hFF;
        endcase
      end
      default: load_val = 8'hFF;
    endcase
  end

  // NOTE: non-blocking assignments for all state; a later assignment in this
  // block overrides an earlier one, which gives csb and byte loads priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      out_cnt   <= '0;
      byte_cnt  <= '0;
      shift_in  <= '0;
      shift_out <= '1;
      addr      <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      outst     <= '0;
      drop_cnt  <= '0;
      miso      <= 1'b1;
      oe        <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      underrun  <= 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast_read <= 1'b0;
      dummy_cnt <= '0;
`endif
    end else begin
      mem_req <= 1'b0;
      outst   <= outst_after;

      // Responses owed to an aborted or underrun byte are dropped in order.
      if (mem_rvalid_i) begin
        if (drop_cnt != 2'd0) begin
          drop_cnt <= drop_cnt - 2'd1;
        end else if (prefetching) begin
          buf_data  <= mem_rdata_i;
          buf_valid <= 1'b1;
        end
      end

      if (csb_rise) begin
        state     <= S_IDLE;
        oe        <= 1'b0;
        miso      <= 1'b1;
        buf_valid <= 1'b0;
        drop_cnt  <= outst_after;
      end else begin
        case (state)
          S_IDLE: begin
            if (csb_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
            end
          end

          S_CMD: begin
            if (sck_rise) begin
              shift_in <= cmd_byte[6:0];
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                out_cnt  <= '0;
                byte_cnt <= '0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                fast_read <= (cmd_byte == CMD_FAST_READ);
`endif
                case (cmd_byte)
                  CMD_READ:        state <= S_ADDR;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                  CMD_FAST_READ:   state <= S_ADDR;
`endif
                  CMD_JEDEC_ID: begin
                    state <= S_ID;
                    oe    <= 1'b1;
                  end
                  CMD_READ_STATUS: begin
                    state <= S_STATUS;
                    oe    <= 1'b1;
                  end
                  default:         state <= S_IGNORE;
                endcase
              end
            end
          end

          S_ADDR: begin
            if (sck_rise) begin
              addr    <= addr_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                bit_cnt  <= '0;
                mem_req  <= 1'b1;
                mem_addr <= addr_next[ADDR_WIDTH-1:0];
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                if (fast_read) begin
                  state     <= S_DUMMY;
                  dummy_cnt <= '0;
                end else begin
                  state <= S_DATA;
                  oe    <= 1'b1;
                end
`else
                state <= S_DATA;
                oe    <= 1'b1;
`endif
              end
            end
          end

`ifdef SPI_FLASH_RESP_FAST_READ_EN
          S_DUMMY: begin
            if (sck_rise) begin
              dummy_cnt <= dummy_cnt + 3'd1;
              if (dummy_cnt == 3'(DUMMY_CYCLES - 1)) begin
                state <= S_DATA;
                oe    <= 1'b1;
              end
            end
          end
`endif

          S_DATA, S_ID, S_STATUS: begin
            if (sck_fall) begin
              out_cnt <= out_cnt + 3'd1;
              if (out_cnt == 3'd0) begin
                // First falling edge of a byte: load the whole byte, MSB out now.
                shift_out <= load_val[6:0];
                miso      <= load_val[7];
                if (state == S_ID && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                if (state == S_DATA) begin
                  if (!buf_valid) underrun <= 1'b1;
                  buf_valid <= 1'b0;
                  drop_cnt  <= outst_after;
                  addr      <= addr_inc;
                  mem_req   <= 1'b1;
                  mem_addr  <= addr_inc[ADDR_WIDTH-1:0];
                end
              end else begin
                shift_out <= {shift_out[5:0], 1'b1};
                miso      <= shift_out[6];
              end
            end
          end

          S_IGNORE: state <= S_IGNORE;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_miso_o    = miso;
  assign spi_miso_oe_o = oe & drives_miso(state);
  assign mem_req_o     = mem_req;
  assign mem_addr_o    = mem_addr;
  assign busy_o        = (state != S_IDLE);
  assign underrun_o    = underrun;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a bit-banged mode-0 initiator and a
// latency-programmable memory model (mem[a] = a[7:0] + 3*a[15:8]).
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        csb = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, mem_req, busy, underrun;
  logic [15:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;

  int checks = 0;
  int errors = 0;

  spi_flash_responder dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .spi_sck_i     (sck),
    .spi_csb_i     (csb),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .busy_o        (busy),
    .underrun_o    (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] + 8'(a[15:8] * 3);
  endfunction

  // Memory model: answers each request exactly once, lat cycles later.
  int          cyc = 0;
  int          lat = 1;
  int          due_q[$];
  logic [15:0] adr_q[$];
  logic [15:0] req_log[$];
  int          oe_cycles = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    mem_rvalid = 1'b0;
    if (miso_oe) oe_cycles = oe_cycles + 1;
    if (mem_req) begin
      due_q.push_back(cyc + lat);
      adr_q.push_back(mem_addr);
      req_log.push_back(mem_addr);
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_byte(adr_q[0]);
      void'(due_q.pop_front());
      void'(adr_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One SPI bit: MOSI set while sck low, MISO sampled at the rising edge.
  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    repeat (5) @(negedge clk);
    sck = 1'b1;
    s = miso;
    repeat (5) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic spi_start();
    @(negedge clk) csb = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_end();
    @(negedge clk) csb = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] rx;
    spi_byte(cmd, rx);
    spi_byte(a[23:16], rx);
    spi_byte(a[15:8], rx);
    spi_byte(a[7:0], rx);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", miso); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read();
    logic [7:0] rx;
    int base;
    lat  = 1;
    base = req_log.size();
    @(negedge clk) csb = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_rise_early: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
    repeat (2) @(negedge clk);
    send_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++;
      if (rx !== mem_byte(16'(16'h0010 + i))) begin
        errors++; $display("FAIL read_byte%0d: got %h expected %h", i, rx, mem_byte(16'(16'h0010 + i)));
      end
    end
    @(negedge clk) csb = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_fall_early: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b expected 0", busy); end
    repeat (10) @(negedge clk);
    checks++;
    if (req_log.size() - base < 4) begin
      errors++; $display("FAIL read_req_count: got %0d expected at least 4", req_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_log[base + i] !== 16'(16'h0010 + i)) begin
          errors++; $display("FAIL read_req_addr%0d: got %h expected %h", i, req_log[base + i], 16'(16'h0010 + i));
        end
      end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL read_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_wrap();
    logic [7:0] rx0, rx1;
    int base;
    lat  = 1;
    base = req_log.size();
    spi_start();
    send_hdr(8'h03, 24'h00FFFF);
    spi_byte(8'h00, rx0);
    spi_byte(8'h00, rx1);
    spi_end();
    checks++; if (rx0 !== 8'hFC) begin errors++; $display("FAIL wrap_byte0: got %h expected fc", rx0); end
    checks++; if (rx1 !== 8'h00) begin errors++; $display("FAIL wrap_byte1: got %h expected 00", rx1); end
    checks++; if (req_log[base] !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0: got %h expected ffff", req_log[base]); end
    checks++; if (req_log[base + 1] !== 16'h0000) begin errors++; $display("FAIL wrap_addr1: got %h expected 0000", req_log[base + 1]); end
  endtask

  task automatic test_id_status();
    logic [7:0] rx;
    logic [7:0] id_exp [4];
    id_exp[0] = 8'hEF; id_exp[1] = 8'h40; id_exp[2] = 8'h18; id_exp[3] = 8'hFF;
    spi_start();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== id_exp[i]) begin errors++; $display("FAIL id_byte%0d: got %h expected %h", i, rx, id_exp[i]); end
    end
    spi_end();
    spi_start();
    spi_byte(8'h05, rx);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL status_byte%0d: got %h expected 00", i, rx); end
    end
    spi_end();
  endtask

  task automatic test_ignore();
    logic [7:0] rx;
    int oe0, base;
    oe0  = oe_cycles;
    base = req_log.size();
    spi_start();
    spi_byte(8'h06, rx);
    spi_byte(8'hA5, rx);
    spi_byte(8'h5A, rx);
    spi_end();
    checks++; if (oe_cycles != oe0) begin errors++; $display("FAIL ignore_oe: got %0d oe cycles expected 0", oe_cycles - oe0); end
    checks++; if (req_log.size() != base) begin errors++; $display("FAIL ignore_req: got %0d requests expected 0", req_log.size() - base); end
    spi_start();
    send_hdr(8'h03, 24'h000123);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h26) begin errors++; $display("FAIL after_ignore_byte0: got %h expected 26", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h27) begin errors++; $display("FAIL after_ignore_byte1: got %h expected 27", rx); end
    spi_end();
  endtask

  task automatic test_abort();
    logic b;
    logic [7:0] rx;
    lat = 1;
    spi_start();
    send_hdr(8'h03, 24'h000080);
    lat = 20;
    spi_bit(1'b0, b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL abort_first_bit: got %b expected 1", b); end
    @(negedge clk) csb = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b expected 0", miso_oe); end
    repeat (30) @(negedge clk);
    lat = 1;
    spi_start();
    send_hdr(8'h03, 24'h000090);
    spi_byte(8'h00, rx);
    spi_end();
    checks++; if (rx !== 8'h90) begin errors++; $display("FAIL abort_next_read: got %h expected 90", rx); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL abort_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_underrun();
    logic [7:0] rx0, rx1;
    lat = 4;
    spi_start();
    send_hdr(8'h03, 24'h000060);
    spi_byte(8'h00, rx0);
    spi_byte(8'h00, rx1);
    spi_end();
    checks++; if (rx0 !== 8'hFF) begin errors++; $display("FAIL underrun_byte0: got %h expected ff", rx0); end
    checks++; if (rx1 !== 8'h61) begin errors++; $display("FAIL underrun_byte1: got %h expected 61", rx1); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b expected 1", underrun); end
    lat = 1;
    spi_start();
    send_hdr(8'h03, 24'h000070);
    spi_byte(8'h00, rx0);
    spi_end();
    checks++; if (rx0 !== 8'h70) begin errors++; $display("FAIL underrun_recover: got %h expected 70", rx0); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun); end
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_reset: got %b expected 0", underrun); end
  endtask

  task automatic test_fast_read();
    logic b;
    logic [7:0] rx;
    int oe0, base;
    lat = 1;
    spi_start();
    send_hdr(8'h0B, 24'h000020);
    oe0  = oe_cycles;
    base = req_log.size();
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    for (int i = 0; i < 7; i++) spi_bit(1'b0, b);
    checks++; if (oe_cycles != oe0) begin errors++; $display("FAIL fast_dummy_oe: got %0d oe cycles expected 0", oe_cycles - oe0); end
    spi_bit(1'b0, b);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h20) begin errors++; $display("FAIL fast_byte0: got %h expected 20", rx); end
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL fast_data_oe: got %b expected 1", miso_oe); end
    spi_end();
`else
    for (int i = 0; i < 8; i++) spi_bit(1'b0, b);
    spi_byte(8'h00, rx);
    spi_end();
    checks++; if (oe_cycles != oe0) begin errors++; $display("FAIL nofast_oe: got %0d oe cycles expected 0", oe_cycles - oe0); end
    checks++; if (req_log.size() != base) begin errors++; $display("FAIL nofast_req: got %0d requests expected 0", req_log.size() - base); end
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_wrap();
    test_id_status();
    test_ignore();
    test_abort();
    test_underrun();
    test_fast_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
